// File: rtl/fa_token_scheduler.sv
// Round-robin scheduler sharing one QDI dual-rail full adder among NREQ clocked requesters.
// Encodes the winner's operand onto 1-of-2 rails, runs both four-phase handshakes, returns {Co,Sum}.
module fa_token_scheduler #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req,
  input  logic [3*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]      gnt,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [1:0]           rsp_data,
  output logic                 rsp_mismatch,
  output logic                 rsp_err,
  output logic                 fault,
  output logic [1:0]           Ax,
  output logic [1:0]           Bx,
  output logic [1:0]           Cx,
  input  logic                 ABCe,
  input  logic [1:0]           Sx,
  input  logic [1:0]           Co,
  output logic                 Sxe,
  output logic                 Coe
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  // IDLE arbitrate | SEND rails valid | NEUT await result | CAPT enables low | RESP deliver | WAITE await ABCe | ERR halted
  typedef enum logic [2:0] {
    ST_IDLE, ST_SEND, ST_NEUT, ST_CAPT, ST_RESP, ST_WAITE, ST_ERR
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [SYNC_STAGES-1:0]          r_abce_sync;
  logic [SYNC_STAGES-1:0][1:0]     r_sx_sync;
  logic [SYNC_STAGES-1:0][1:0]     r_co_sync;
  logic                            w_abce_s;
  logic [1:0]                      w_sx_s;
  logic [1:0]                      w_co_s;
  logic [7:0]                      r_wait_cnt;
  logic                            w_tmo;
  logic [2:0]                      r_ptr;
  logic [2:0]                      r_id;
  logic [2:0]                      r_opnd;
  logic [1:0]                      r_sx_lat;
  logic [1:0]                      r_co_lat;
  logic                            w_found;
  logic [2:0]                      w_win;
  logic [3:0]                      w_idx;
  logic [2:0]                      w_win_data;
  logic [2:0]                      w_opnd_src;
  logic [NREQ-1:0]                 w_onehot;
  logic [1:0]                      w_pop;
  logic [1:0]                      w_dec;
  logic                            w_illegal;
  logic [2:0]                      w_ptr_nxt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_abce_sync <= '0;
      r_sx_sync   <= '0;
      r_co_sync   <= '0;
    end else begin
      r_abce_sync <= {r_abce_sync[SYNC_STAGES-2:0], ABCe};
      r_sx_sync   <= {r_sx_sync[SYNC_STAGES-2:0], Sx};
      r_co_sync   <= {r_co_sync[SYNC_STAGES-2:0], Co};
    end
  end

  assign w_abce_s = r_abce_sync[SYNC_STAGES-1];
  assign w_sx_s   = r_sx_sync[SYNC_STAGES-1];
  assign w_co_s   = r_co_sync[SYNC_STAGES-1];
  assign w_tmo    = (r_wait_cnt == TMO);

  // Descending scan so the smallest offset from r_ptr is the last (winning) assignment.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      if (w_idx >= 4'(NREQ)) w_idx = w_idx - 4'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if (w_idx == 4'(i) && req[i]) begin
          w_found = 1'b1;
          w_win   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    w_onehot   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 3'(i)) w_win_data = req_data[3*i +: 3];
      if (r_id == 3'(i))  w_onehot[i] = 1'b1;
    end
  end

  assign w_opnd_src = (r_state == ST_IDLE) ? w_win_data : r_opnd;
  assign w_pop      = 2'(r_opnd[0]) + 2'(r_opnd[1]) + 2'(r_opnd[2]);
  assign w_dec      = {r_co_lat == 2'b10, r_sx_lat == 2'b10};
  assign w_illegal  = (r_sx_lat == 2'b11) || (r_co_lat == 2'b11);
  assign w_ptr_nxt  = (r_id == 3'(NREQ - 1)) ? 3'd0 : r_id + 3'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_found && w_abce_s) w_state_nxt = ST_SEND;
      ST_SEND:  if (!w_abce_s) w_state_nxt = ST_NEUT;
                else if (w_tmo) w_state_nxt = ST_ERR;
      ST_NEUT:  if (w_sx_s != 2'b00 && w_co_s != 2'b00) w_state_nxt = ST_CAPT;
                else if (w_tmo) w_state_nxt = ST_ERR;
      ST_CAPT:  if (w_sx_s == 2'b00 && w_co_s == 2'b00) w_state_nxt = ST_RESP;
                else if (w_tmo) w_state_nxt = ST_ERR;
      ST_RESP:  w_state_nxt = ST_WAITE;
      ST_WAITE: if (w_abce_s) w_state_nxt = ST_IDLE;
                else if (w_tmo) w_state_nxt = ST_ERR;
      ST_ERR:   w_state_nxt = ST_ERR;
      default:  w_state_nxt = ST_ERR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_ptr      <= '0;
      r_id       <= '0;
      r_opnd     <= '0;
      r_sx_lat   <= '0;
      r_co_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_wait_cnt <= '0;
      else if (!w_tmo)            r_wait_cnt <= r_wait_cnt + 8'd1;
      if (r_state == ST_IDLE && w_state_nxt == ST_SEND) begin
        r_id   <= w_win;
        r_opnd <= w_win_data;
      end
      if (r_state == ST_NEUT && w_state_nxt == ST_CAPT) begin
        r_sx_lat <= w_sx_s;
        r_co_lat <= w_co_s;
      end
      if (r_state == ST_CAPT && w_state_nxt == ST_RESP) r_ptr <= w_ptr_nxt;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Ax           <= 2'b00;
      Bx           <= 2'b00;
      Cx           <= 2'b00;
      Sxe          <= 1'b1;
      Coe          <= 1'b1;
      gnt          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_mismatch <= 1'b0;
      rsp_err      <= 1'b0;
      fault        <= 1'b0;
    end else begin
      if (w_state_nxt == ST_SEND) begin
        Ax <= {w_opnd_src[0], ~w_opnd_src[0]};
        Bx <= {w_opnd_src[1], ~w_opnd_src[1]};
        Cx <= {w_opnd_src[2], ~w_opnd_src[2]};
      end else begin
        Ax <= 2'b00;
        Bx <= 2'b00;
        Cx <= 2'b00;
      end
      Sxe       <= (w_state_nxt != ST_CAPT);
      Coe       <= (w_state_nxt != ST_CAPT);
      gnt       <= '0;
      rsp_valid <= 1'b0;
      if (r_state == ST_CAPT && w_state_nxt == ST_RESP) begin
        gnt          <= w_onehot;
        rsp_valid    <= 1'b1;
        rsp_id       <= r_id;
        rsp_data     <= w_dec;
        rsp_mismatch <= (w_dec != w_pop);
        rsp_err      <= w_illegal;
      end else if (r_state != ST_ERR && w_state_nxt == ST_ERR) begin
        gnt          <= w_onehot;
        rsp_valid    <= 1'b1;
        rsp_id       <= r_id;
        rsp_data     <= 2'b00;
        rsp_mismatch <= 1'b0;
        rsp_err      <= 1'b1;
        fault        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fa_token_scheduler.sv
// Bench for fa_token_scheduler: behavioural QDI adder with fault modes, scoreboard of expected responses.
module tb_fa_token_scheduler;

  localparam int NREQ = 4;
  localparam int M_NORM = 0, M_SUMBUG = 1, M_COILL = 2, M_STUCK = 3;

  typedef struct packed {
    logic [2:0] id;
    logic [1:0] data;
    logic       mism;
    logic       err;
  } exp_t;

  logic CLK = 1'b0;
  logic mclk = 1'b0;
  logic RESET;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic [2:0]        rsp_id;
  logic [1:0]        rsp_data;
  logic              rsp_mismatch, rsp_err, fault;
  logic [1:0]        Ax, Bx, Cx;
  logic              ABCe = 1'b1;
  logic [1:0]        Sx = 2'b00;
  logic [1:0]        Co = 2'b00;
  logic              Sxe, Coe;
  logic              adder_rst;
  int                mode;
  int                ph = 0;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 CLK = ~CLK;
  always #7 mclk = ~mclk;

  fa_token_scheduler #(.NREQ(NREQ), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_mismatch(rsp_mismatch), .rsp_err(rsp_err), .fault(fault),
    .Ax(Ax), .Bx(Bx), .Cx(Cx), .ABCe(ABCe), .Sx(Sx), .Co(Co), .Sxe(Sxe), .Coe(Coe)
  );

  function automatic logic rail_ok(input logic [1:0] r);
    return (r == 2'b10) || (r == 2'b01);
  endfunction

  // {carry, sum} of the operand carried on the rails, with the modelled faults applied.
  function automatic logic [3:0] adder_out(input logic [2:0] o, input int md);
    logic s, c;
    s = o[0] ^ o[1] ^ o[2];
    c = (o[0] & o[1]) | (o[0] & o[2]) | (o[1] & o[2]);
    if (md == M_SUMBUG && o == 3'b000) s = 1'b1;
    return {(md == M_COILL) ? 2'b11 : (c ? 2'b10 : 2'b01), s ? 2'b10 : 2'b01};
  endfunction

  always @(posedge mclk or posedge adder_rst) begin
    if (adder_rst) begin
      ABCe <= 1'b1;
      Sx   <= 2'b00;
      Co   <= 2'b00;
      ph   <= 0;
    end else begin
      case (ph)
        0: if (rail_ok(Ax) && rail_ok(Bx) && rail_ok(Cx) && Sxe && Coe && mode != M_STUCK) begin
             {Co, Sx} <= adder_out({Cx[1], Bx[1], Ax[1]}, mode);
             ph <= 1;
           end
        1: begin ABCe <= 1'b0; ph <= 2; end
        2: if (Ax == 2'b00 && Bx == 2'b00 && Cx == 2'b00 && !Sxe && !Coe) begin
             Sx <= 2'b00;
             Co <= 2'b00;
             ph <= 3;
           end
        default: begin ABCe <= 1'b1; ph <= 0; end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RESET === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got id %0d gnt %0h, expected no response", rsp_id, gnt);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(e.mism));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("gnt_onehot", 32'(gnt), 32'(4'b0001 << e.id));
      end
    end
  end

  task automatic wait_gnt(input int i, input int budget);
    int  n;
    bit  got;
    n = 0;
    got = 0;
    while (!got && n < budget) begin
      @(negedge CLK);
      if (gnt[i]) got = 1;
      n++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL gnt_wait: requester %0d got no grant in %0d cycles, expected one", i, budget);
    end
  endtask

  task automatic token(input int i, input logic [2:0] op, input logic [1:0] d,
                       input logic m, input logic er);
    @(negedge CLK);
    req_data[3*i +: 3] = op;
    req[i] = 1'b1;
    sb.push_back({3'(i), d, m, er});
    wait_gnt(i, 400);
    req[i] = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_Ax"}, 32'(Ax), 32'd0);
    chk({tag, "_Bx"}, 32'(Bx), 32'd0);
    chk({tag, "_Cx"}, 32'(Cx), 32'd0);
    chk({tag, "_Sxe"}, 32'(Sxe), 32'd1);
    chk({tag, "_Coe"}, 32'(Coe), 32'd1);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [1:0] sum_tab [8];
    logic [2:0] rr_op [4];
    logic [1:0] rr_d [4];
    int n, cyc;
    sum_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rr_op   = '{3'b001, 3'b110, 3'b111, 3'b000};
    rr_d    = '{2'b01, 2'b10, 2'b11, 2'b00};

    RESET = 1'b1;
    adder_rst = 1'b0;
    req = '0;
    req_data = '0;
    mode = M_NORM;
    #2;
    RESET = 1'b0;
    adder_rst = 1'b1;
    #1;
    check_idle_outputs("reset");
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk("reset_rsp_mismatch", 32'(rsp_mismatch), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    adder_rst = 1'b0;

    for (int op = 0; op < 8; op++) token(0, 3'(op), sum_tab[op], 1'b0, 1'b0);

    mode = M_SUMBUG;
    token(1, 3'b000, 2'b01, 1'b1, 1'b0);

    mode = M_COILL;
    token(2, 3'b011, 2'b00, 1'b1, 1'b1);
    chk("coill_fault", 32'(fault), 32'd0);
    mode = M_NORM;
    token(3, 3'b101, 2'b10, 1'b0, 1'b0);

    // Abort a token while the output enables are low.
    @(negedge CLK);
    req_data[2:0] = 3'b111;
    req[0] = 1'b1;
    cyc = 0;
    while (Sxe !== 1'b0 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
    chk("capt_reached", 32'(Sxe), 32'd0);
    #2;
    RESET = 1'b0;
    adder_rst = 1'b1;
    #1;
    check_idle_outputs("midreset");
    chk("midreset_fault", 32'(fault), 32'd0);
    req = '0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    adder_rst = 1'b0;

    @(negedge CLK);
    for (int i = 0; i < NREQ; i++) req_data[3*i +: 3] = rr_op[i];
    for (int k = 0; k < 8; k++) sb.push_back({3'(k % 4), rr_d[k % 4], 1'b0, 1'b0});
    req = 4'hF;
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (gnt != '0) begin
        chk("rr_order", 32'(gnt), 32'(4'b0001 << (n % 4)));
        n++;
      end
    end
    req = '0;
    chk("rr_grants", 32'(n), 32'd8);

    mode = M_STUCK;
    token(0, 3'b001, 2'b00, 1'b0, 1'b1);
    @(negedge CLK);
    chk("tmo_fault", 32'(fault), 32'd1);
    chk("tmo_Ax", 32'(Ax), 32'd0);
    chk("tmo_Bx", 32'(Bx), 32'd0);
    chk("tmo_Cx", 32'(Cx), 32'd0);
    mode = M_NORM;
    req_data[5:3] = 3'b010;
    req[1] = 1'b1;
    n = 0;
    repeat (60) begin
      @(negedge CLK);
      if (gnt != '0) n++;
    end
    req = '0;
    chk("err_no_gnt", 32'(n), 32'd0);
    chk("err_fault_sticky", 32'(fault), 32'd1);

    RESET = 1'b0;
    adder_rst = 1'b1;
    #1;
    chk("final_fault_cleared", 32'(fault), 32'd0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    adder_rst = 1'b0;
    repeat (5) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
